muldiv_unit: RTL
================

# muldiv_unit

Parametrised multiply/divide unit for the EX stage of the pipelined MIPS core, owning the HI/LO register pair. It adds operand width, multiply latency, multiply-accumulate operations and a flush/abort path. Division is a true iterative restoring divider, not a delayed one-shot result. The hazard unit stalls on `start`/`busy`.

## Interface
Parameters:
- `WIDTH`, 32, operand and HI/LO width (even, ≥ 8)
- `MUL_LAT`, 5, cycles `busy` stays high for any multiply-class op (≥ 1)

Ports:
- `clk`  in  1  clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `op`  in  4  operation code from `md_pkg`; `MD_NOP` when idle
- `a`  in  WIDTH  operand rs
- `b`  in  WIDTH  operand rt
- `int_req`  in  1  interrupt pending; blocks acceptance of any op this cycle
- `flush`  in  1  abort the in-flight operation
- `start`  out  1  combinational: `op` is MULT/MULTU/DIV/DIVU/MADD/MADDU/MSUB/MSUBU
- `busy`  out  1  operation in flight
- `hi`  out  WIDTH  HI register
- `lo`  out  WIDTH  LO register
- `md_res`  out  WIDTH  combinational: HI for MFHI, LO for MFLO, else 0

## Operation
- Reset: `hi`=0, `lo`=0, `busy`=0, internal counter and divider state cleared. `md_res`=0 unless `op` is MFHI/MFLO.
- **Accept rule:** an op is accepted at a rising edge only when `busy`=0, `int_req`=0 and `flush`=0. With `busy`=1, every op except MFHI/MFLO is ignored; the core stalls it.
- **MTHI / MTLO:** accepted edge writes `a` to HI or LO. `busy` is unaffected.
- **MFHI / MFLO:** pure combinational read, legal even while busy. Returns the current register, not the pending result.
- **MULT / MULTU:** full 2·WIDTH product, signed or unsigned. Result is written to {HI,LO}.
- **MADD / MADDU / MSUB / MSUBU:** {HI,LO} ± product. The {HI,LO} value used is the one at completion; MTHI/MTLO cannot intervene because they are ignored while busy. Arithmetic wraps modulo 2^(2·WIDTH).
- **DIV / DIVU:**
  - LO = quotient, HI = remainder.
  - Signed: quotient truncates toward zero; remainder takes the sign of the dividend.
  - Most-negative ÷ −1: LO = most-negative, HI = 0.
  - Implementation: magnitudes, one restoring step per cycle, sign fix-up in the final cycle.
- **Divide by zero:** the op is accepted and `busy` holds 1 for one cycle. HI and LO stay unchanged.
- **State machine:** IDLE → MUL (counter = MUL_LAT) or DIV (counter = WIDTH+1) → IDLE.
  - The counter decrements each cycle.
  - At the edge where it reaches 0, the result is written and `busy` falls.
- **Flush while busy:** the operation is discarded. HI and LO are untouched and the state returns to IDLE. `busy`=0 after that edge.
- **Flush together with a new op at an idle edge:** the op is not accepted.

## Timing
- Op accepted at edge E0 → `busy`=1 from E0.
- Multiply class: HI/LO updated and `busy`=0 at edge E0+MUL_LAT.
- Divide: HI/LO updated and `busy`=0 at E0+WIDTH+1. Divide by zero: `busy`=0 at E0+1.
- A new op can be accepted on the same edge at which `busy` falls? No. `busy` is sampled as 1 at that edge, so the earliest next accept is the following edge.
- MTHI/MTLO take effect at the accept edge; a subsequent MFHI/MFLO sees the value one cycle later.
- Reset asserted mid-operation clears immediately and asynchronously; no partial result is written.

## Structure
- Package `md_pkg`: 4-bit op codes
  - `MD_NOP`=0, `MD_MULT`=1, `MD_MULTU`=2, `MD_DIV`=3, `MD_DIVU`=4
  - `MD_MADD`=5, `MD_MADDU`=6, `MD_MSUB`=7, `MD_MSUBU`=8
  - `MD_MTHI`=9, `MD_MTLO`=10, `MD_MFHI`=11, `MD_MFLO`=12
  - `is_start_op` helper function
- Sub-module `md_divider`: iterative unsigned restoring divider.
  - Parameterised by WIDTH.
  - Signals: `load`, `abort`, `done`; outputs `quot` and `rem`.
  - Sign handling stays in `muldiv_unit`.
- The multiplier is computed at accept, held in a 2·WIDTH register, and committed when the counter expires. This is the retiming point for synthesis.

## Test plan
- MULT a=0xFFFFFFFE, b=3 (−2·3) → after 5 cycles HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU same → HI=0x2, LO=0xFFFFFFFA.
- DIV a=−7, b=2 → `busy` 33 cycles, LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 100/7 → LO=14, HI=2; DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MTHI 5, MTLO 9, DIV x/0 → `busy` 1 cycle, HI=5, LO=9 unchanged.
- HI=0, LO=0xFFFFFFFF, MADDU 1·1 → HI=1, LO=0; then MSUB 1·1 → HI=0, LO=0xFFFFFFFF.
- DIVU issued, `flush` at cycle 10 → `busy`=0 next edge, HI/LO unchanged; MULT presented with `int_req`=1 → not accepted, `busy` stays 0.
- MTLO while busy ignored; MFLO while busy returns old LO; async `reset` mid-DIV → HI=LO=0, `busy`=0 immediately.

Source files
------------

// File: rtl/md_pkg.sv
// rtl/md_pkg.sv - op codes, FSM states and op classification helpers for muldiv_unit
package md_pkg;

    typedef enum logic [3:0] {
        MD_NOP   = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MADD  = 4'd5,
        MD_MADDU = 4'd6,
        MD_MSUB  = 4'd7,
        MD_MSUBU = 4'd8,
        MD_MTHI  = 4'd9,
        MD_MTLO  = 4'd10,
        MD_MFHI  = 4'd11,
        MD_MFLO  = 4'd12
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV
    } md_state_e;

    function automatic logic is_start_op(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_MSUBU);
    endfunction

    function automatic logic is_signed_op(input logic [3:0] op);
        return (op == MD_MULT) || (op == MD_DIV) || (op == MD_MADD) || (op == MD_MSUB);
    endfunction

endpackage

// File: rtl/md_divider.sv
// rtl/md_divider.sv - iterative unsigned restoring divider, one quotient bit per cycle
module md_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);
    localparam int SW = $clog2(WIDTH + 1);

    logic             run_q, run_d;
    logic [SW-1:0]    step_q, step_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvsr_q, dvsr_d;
    logic [WIDTH:0]   shifted;

    always_comb begin
        run_d   = run_q;
        step_d  = step_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        shifted = {rem_q, quot_q[WIDTH-1]};
        if (abort) begin
            run_d = 1'b0;
        end else if (load) begin
            run_d  = 1'b1;
            step_d = '0;
            quot_d = dividend;
            rem_d  = '0;
            dvsr_d = divisor;
        end else if (run_q && (step_q != SW'(WIDTH))) begin
            step_d = step_q + SW'(1);
            // remainder stays below the divisor, so the low WIDTH bits of the difference are exact
            if (shifted >= {1'b0, dvsr_q}) begin
                rem_d  = shifted[WIDTH-1:0] - dvsr_q;
                quot_d = {quot_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d  = shifted[WIDTH-1:0];
                quot_d = {quot_q[WIDTH-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            run_q  <= 1'b0;
            step_q <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dvsr_q <= '0;
        end else begin
            run_q  <= run_d;
            step_q <= step_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dvsr_q <= dvsr_d;
        end
    end

    assign done = run_q && (step_q == SW'(WIDTH));
    assign quot = quot_q;
    assign rem  = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - EX-stage multiply/divide unit owning HI/LO
// Multiplies are computed at accept and committed after MUL_LAT cycles; divides iterate.
module muldiv_unit
    import md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int MUL_LAT = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             int_req,
    input  logic             flush,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] md_res
);
    localparam int CNT_MAX = (MUL_LAT > WIDTH + 1) ? MUL_LAT : WIDTH + 1;
    localparam int CW      = $clog2(CNT_MAX + 1);

    md_state_e          state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [3:0]         op_q, op_d;
    logic               q_neg_q, q_neg_d, r_neg_q, r_neg_d, dz_q, dz_d;

    logic               accept, a_neg, b_neg, div_load, div_abort, div_done;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag, div_quot, div_rem;
    logic [2*WIDTH-1:0] prod_in, acc, mul_res;

    assign busy    = (state_q != ST_IDLE);
    assign start   = is_start_op(op);
    assign accept  = !busy && !int_req && !flush;
    assign a_neg   = is_signed_op(op) && a[WIDTH-1];
    assign b_neg   = is_signed_op(op) && b[WIDTH-1];
    assign dvd_mag = a_neg ? -a : a;
    assign dvs_mag = b_neg ? -b : b;
    assign prod_in = {{WIDTH{a_neg}}, a} * {{WIDTH{b_neg}}, b};
    assign acc     = {hi_q, lo_q};

    always_comb begin
        mul_res = prod_q;
        if ((op_q == MD_MADD) || (op_q == MD_MADDU)) mul_res = acc + prod_q;
        if ((op_q == MD_MSUB) || (op_q == MD_MSUBU)) mul_res = acc - prod_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        prod_d    = prod_q;
        op_d      = op_q;
        q_neg_d   = q_neg_q;
        r_neg_d   = r_neg_q;
        dz_d      = dz_q;
        div_load  = 1'b0;
        div_abort = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (op)
                        MD_MTHI: hi_d = a;
                        MD_MTLO: lo_d = a;
                        MD_MULT, MD_MULTU, MD_MADD, MD_MADDU, MD_MSUB, MD_MSUBU: begin
                            state_d = ST_MUL;
                            cnt_d   = CW'(MUL_LAT);
                            op_d    = op;
                            prod_d  = prod_in;
                        end
                        MD_DIV, MD_DIVU: begin
                            state_d = ST_DIV;
                            op_d    = op;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                            dz_d    = (b == '0);
                            cnt_d   = (b == '0) ? CW'(1) : CW'(WIDTH + 1);
                            div_load = (b != '0);
                        end
                        default: ;
                    endcase
                end
            end
            default: begin
                if (flush) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    div_abort = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        state_d = ST_IDLE;
                        if (state_q == ST_MUL) begin
                            {hi_d, lo_d} = mul_res;
                        end else begin
                            div_abort = 1'b1;
                            // final divide cycle: restore signs on the magnitude results
                            if (!dz_q && div_done) begin
                                lo_d = q_neg_q ? -div_quot : div_quot;
                                hi_d = r_neg_q ? -div_rem : div_rem;
                            end
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            op_q    <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            op_q    <= op_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            dz_q    <= dz_d;
        end
    end

    md_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load),
        .abort    (div_abort),
        .dividend (dvd_mag),
        .divisor  (dvs_mag),
        .done     (div_done),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_comb begin
        md_res = '0;
        if (op == MD_MFHI) md_res = hi_q;
        if (op == MD_MFLO) md_res = lo_q;
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule
